// File: rtl/dm_bytelane.sv
// Byte-lane data memory for the MEM stage: byte/half/word loads and stores with a req/ready
// handshake and WAIT extra cycles per access.
module dm_bytelane #(
    parameter int    DEPTH     = 1024,
    parameter int    WAIT      = 0,
    parameter string INIT_FILE = "./data.txt"
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        misalign,
    output logic        busy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int AW    = IDX_W + 2;
    localparam logic [3:0] WAIT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    typedef enum logic {IDLE, WAITING} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [AW-1:0]     addr_q;
    logic [31:0]       wdata_q;

    logic [31:0]       mem [DEPTH];

    // Effective access fields: live inputs when completing in IDLE, latched copies in WAITING.
    logic              a_we;
    logic [1:0]        a_size;
    logic              a_uns;
    logic [AW-1:0]     a_addr;
    logic [31:0]       a_wdata;
    logic [IDX_W-1:0]  idx;
    logic              fire;
    logic              mis;
    logic [3:0]        be;
    logic [31:0]       wword;
    logic [31:0]       rd_word;
    logic [31:0]       ld_val;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;

    logic              unused_addr_bits;
    assign unused_addr_bits = ^addr[31:AW];

    always_comb begin
        if (state == IDLE) begin
            a_we    = we;
            a_size  = size;
            a_uns   = uns;
            a_addr  = addr[AW-1:0];
            a_wdata = wdata;
        end else begin
            a_we    = we_q;
            a_size  = size_q;
            a_uns   = uns_q;
            a_addr  = addr_q;
            a_wdata = wdata_q;
        end
    end

    assign idx  = a_addr[AW-1:2];
    assign fire = (state == IDLE && req && WAIT == 0) || (state == WAITING && cnt == '0);
    assign mis  = (a_size == 2'b11) ||
                  (a_size == 2'b01 && a_addr[0]) ||
                  (a_size == 2'b10 && a_addr[1:0] != 2'b00);

    // Store data is replicated across lanes so the byte enables alone pick the target bytes.
    always_comb begin
        be    = 4'b0000;
        wword = a_wdata;
        case (a_size)
            2'b00: begin
                be[a_addr[1:0]] = 1'b1;
                wword           = {4{a_wdata[7:0]}};
            end
            2'b01: begin
                be    = a_addr[1] ? 4'b1100 : 4'b0011;
                wword = {2{a_wdata[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    assign rd_word = mem[idx];
    assign ld_byte = rd_word[{a_addr[1:0], 3'b000} +: 8];
    assign ld_half = a_addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        ld_val = '0;
        case (a_size)
            2'b00:   ld_val = {{24{~a_uns & ld_byte[7]}}, ld_byte};
            2'b01:   ld_val = {{16{~a_uns & ld_half[15]}}, ld_half};
            2'b10:   ld_val = rd_word;
            default: ld_val = '0;
        endcase
    end

    // NOTE: the array has no reset branch; clearing it would turn RAM into flops. Writes are
    // still gated by rst_n so an access coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && fire && a_we && !mis) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
            end
        end
    end

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            we_q     <= 1'b0;
            size_q   <= '0;
            uns_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata    <= '0;
            ready    <= 1'b0;
            misalign <= 1'b0;
            busy     <= 1'b0;
        end else begin
            ready    <= 1'b0;
            misalign <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        size_q  <= size;
                        uns_q   <= uns;
                        addr_q  <= addr[AW-1:0];
                        wdata_q <= wdata;
                        if (WAIT != 0) begin
                            cnt   <= WAIT_INIT;
                            state <= WAITING;
                            busy  <= 1'b1;
                        end
                    end
                end
                WAITING: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (fire) begin
                ready    <= 1'b1;
                misalign <= mis;
                rdata    <= (!mis && !a_we) ? ld_val : 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_dm_bytelane.sv
// Directed bench for dm_bytelane: three instances with WAIT = 0, 2 and 3 sharing one clock.
module tb_dm_bytelane;

    logic        clk;
    logic        rst_n    [3];
    logic        req      [3];
    logic        we       [3];
    logic [1:0]  size     [3];
    logic        uns      [3];
    logic [31:0] addr     [3];
    logic [31:0] wdata    [3];
    logic [31:0] rdata    [3];
    logic        ready    [3];
    logic        misalign [3];
    logic        busy     [3];

    int n_checks = 0;
    int n_fail   = 0;

    dm_bytelane #(.DEPTH(1024), .WAIT(0)) u_w0 (
        .clk(clk), .rst_n(rst_n[0]), .req(req[0]), .we(we[0]), .size(size[0]), .uns(uns[0]),
        .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]),
        .misalign(misalign[0]), .busy(busy[0]));
    dm_bytelane #(.DEPTH(1024), .WAIT(2)) u_w2 (
        .clk(clk), .rst_n(rst_n[1]), .req(req[1]), .we(we[1]), .size(size[1]), .uns(uns[1]),
        .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]),
        .misalign(misalign[1]), .busy(busy[1]));
    dm_bytelane #(.DEPTH(1024), .WAIT(3)) u_w3 (
        .clk(clk), .rst_n(rst_n[2]), .req(req[2]), .we(we[2]), .size(size[2]), .uns(uns[2]),
        .addr(addr[2]), .wdata(wdata[2]), .rdata(rdata[2]), .ready(ready[2]),
        .misalign(misalign[2]), .busy(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_mis;
    } vec_t;

    vec_t vecs [30];

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int d, input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd);
        req[d]   = 1'b1;
        we[d]    = w;
        size[d]  = sz;
        uns[d]   = u;
        addr[d]  = a;
        wdata[d] = wd;
    endtask

    // Request presented at a negedge, taken at the following rising edge.
    task automatic issue(input int d, input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        drive(d, w, sz, u, a, wd);
        @(posedge clk);
        #1;
        req[d] = 1'b0;
    endtask

    task automatic access(input int d, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd, input string tag,
                          output logic [31:0] rd, output logic mis);
        int n;
        issue(d, w, sz, u, a, wd);
        n = 0;
        while (!ready[d] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(wait_of(d)));
        check({tag, " busy@ready"}, 32'(busy[d]), 32'h0);
        rd  = rdata[d];
        mis = misalign[d];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        mis;

        vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h10,   32'h11223344, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'h11223344, 1'b0};
        vecs[2]  = '{1'b1, 2'b00, 1'b0, 32'h11,   32'h000000AA, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'h1122AA44, 1'b0};
        vecs[4]  = '{1'b0, 2'b00, 1'b0, 32'h11,   32'h0,        32'hFFFFFFAA, 1'b0};
        vecs[5]  = '{1'b0, 2'b00, 1'b1, 32'h11,   32'h0,        32'h000000AA, 1'b0};
        vecs[6]  = '{1'b1, 2'b01, 1'b0, 32'h12,   32'h00008001, 32'h0,        1'b0};
        vecs[7]  = '{1'b0, 2'b01, 1'b0, 32'h12,   32'h0,        32'hFFFF8001, 1'b0};
        vecs[8]  = '{1'b0, 2'b01, 1'b1, 32'h12,   32'h0,        32'h00008001, 1'b0};
        vecs[9]  = '{1'b0, 2'b01, 1'b0, 32'h13,   32'h0,        32'h0,        1'b1};
        vecs[10] = '{1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'h8001AA44, 1'b0};
        vecs[11] = '{1'b1, 2'b10, 1'b0, 32'h13,   32'hFFFFFFFF, 32'h0,        1'b1};
        vecs[12] = '{1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'h8001AA44, 1'b0};
        vecs[13] = '{1'b1, 2'b11, 1'b0, 32'h10,   32'hFFFFFFFF, 32'h0,        1'b1};
        vecs[14] = '{1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'h8001AA44, 1'b0};
        vecs[15] = '{1'b1, 2'b10, 1'b0, 32'h1004, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[16] = '{1'b0, 2'b10, 1'b0, 32'h4,    32'h0,        32'hDEADBEEF, 1'b0};
        vecs[17] = '{1'b0, 2'b00, 1'b0, 32'h7,    32'h0,        32'hFFFFFFDE, 1'b0};
        vecs[18] = '{1'b0, 2'b01, 1'b0, 32'h4,    32'h0,        32'hFFFFBEEF, 1'b0};
        vecs[19] = '{1'b0, 2'b00, 1'b1, 32'h4,    32'h0,        32'h000000EF, 1'b0};
        vecs[20] = '{1'b0, 2'b10, 1'b1, 32'h4,    32'h0,        32'hDEADBEEF, 1'b0};
        vecs[21] = '{1'b1, 2'b01, 1'b0, 32'h6,    32'hABCD1234, 32'h0,        1'b0};
        vecs[22] = '{1'b0, 2'b10, 1'b0, 32'h4,    32'h0,        32'h1234BEEF, 1'b0};
        vecs[23] = '{1'b1, 2'b00, 1'b0, 32'h4,    32'h12345655, 32'h0,        1'b0};
        vecs[24] = '{1'b0, 2'b00, 1'b1, 32'h4,    32'h0,        32'h00000055, 1'b0};
        vecs[25] = '{1'b0, 2'b10, 1'b0, 32'h4,    32'h0,        32'h1234BE55, 1'b0};
        vecs[26] = '{1'b0, 2'b01, 1'b1, 32'h6,    32'h0,        32'h00001234, 1'b0};
        vecs[27] = '{1'b0, 2'b01, 1'b0, 32'h6,    32'h0,        32'h00001234, 1'b0};
        vecs[28] = '{1'b0, 2'b01, 1'b1, 32'h10,   32'h0,        32'h0000AA44, 1'b0};
        vecs[29] = '{1'b0, 2'b10, 1'b0, 32'h1004, 32'h0,        32'h1234BE55, 1'b0};

        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0;
            req[d]   = 1'b0;
            we[d]    = 1'b0;
            size[d]  = 2'b10;
            uns[d]   = 1'b0;
            addr[d]  = '0;
            wdata[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset rdata[%0d]", d), rdata[d], 32'h0);
            check($sformatf("reset ready[%0d]", d), 32'(ready[d]), 32'h0);
            check($sformatf("reset misalign[%0d]", d), 32'(misalign[d]), 32'h0);
            check($sformatf("reset busy[%0d]", d), 32'(busy[d]), 32'h0);
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;

        // Zero-wait instance: back-to-back accesses from the table.
        for (int i = 0; i < 30; i++) begin
            access(0, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                   $sformatf("vec%0d", i), rd, mis);
            check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d misalign", i), 32'(mis), 32'(vecs[i].exp_mis));
        end

        // ready is a single pulse and rdata holds while idle.
        @(posedge clk);
        #1;
        check("w0 ready pulse", 32'(ready[0]), 32'h0);
        repeat (4) @(posedge clk);
        #1;
        check("w0 rdata hold", rdata[0], 32'h1234BE55);

        // WAIT=2: busy window, ignored request, back-to-back acceptance in the ready cycle.
        access(1, 1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, "w2 sw", rd, mis);
        issue(1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        check("w2 busy k", 32'(busy[1]), 32'h1);
        check("w2 ready k", 32'(ready[1]), 32'h0);
        @(negedge clk);
        drive(1, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0);
        @(posedge clk);
        #1;
        req[1] = 1'b0;
        check("w2 busy k+1", 32'(busy[1]), 32'h1);
        check("w2 ready k+1", 32'(ready[1]), 32'h0);
        @(posedge clk);
        #1;
        check("w2 ready k+2", 32'(ready[1]), 32'h1);
        check("w2 busy k+2", 32'(busy[1]), 32'h0);
        check("w2 rdata k+2", rdata[1], 32'hCAFEF00D);
        check("w2 misalign k+2", 32'(misalign[1]), 32'h0);
        drive(1, 1'b0, 2'b00, 1'b1, 32'h43, 32'h0);
        @(posedge clk);
        #1;
        req[1] = 1'b0;
        check("w2 ready k+3", 32'(ready[1]), 32'h0);
        check("w2 busy k+3", 32'(busy[1]), 32'h1);
        @(posedge clk);
        #1;
        check("w2 ready k+4", 32'(ready[1]), 32'h0);
        @(posedge clk);
        #1;
        check("w2 ready k+5", 32'(ready[1]), 32'h1);
        check("w2 rdata k+5", rdata[1], 32'h000000CA);

        // WAIT=3: reset mid-wait drops the pending store.
        access(2, 1'b1, 2'b10, 1'b0, 32'h20, 32'h13579BDF, "w3 sw", rd, mis);
        access(2, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, "w3 lw", rd, mis);
        check("w3 lw rdata", rd, 32'h13579BDF);
        issue(2, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0);
        @(posedge clk);
        #1;
        check("w3 busy mid", 32'(busy[2]), 32'h1);
        @(negedge clk);
        rst_n[2] = 1'b0;
        #1;
        check("w3 rst ready", 32'(ready[2]), 32'h0);
        check("w3 rst busy", 32'(busy[2]), 32'h0);
        check("w3 rst rdata", rdata[2], 32'h0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n[2] = 1'b1;
        access(2, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, "w3 lw after rst", rd, mis);
        check("w3 store dropped", rd, 32'h13579BDF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
